tlb_op_unit: RTL and testbench
==============================

# tlb_op_unit

Control sequencer that executes TLB maintenance instructions (TLBSRCH, TLBRD, TLBWR, TLBFILL, INVTLB) against the 16-entry TLB. It sits between the EX stage and the TLB's write, read, search-port-1 and invtlb ports. It takes operands from TLB-related CSR values, drives one TLB access, and returns CSR update data with a done pulse. During its EXEC cycle it also steers the shared search port 1 away from load/store.

## Interface
- TLBNUM, 16, number of TLB entries; index width IW = $clog2(TLBNUM).
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- op_valid  in  1  EX requests an operation.
- op_ready  out  1  high only in IDLE; an operation is accepted when op_valid && op_ready.
- op_type  in  3  0 SRCH, 1 RD, 2 WR, 3 FILL, 4 INV; 5-7 are illegal.
- inv_op  in  5  invtlb opcode.
- inv_asid  in  10  ASID operand for invtlb.
- inv_vppn  in  19  VA[31:13] operand for invtlb.
- csr_ehi_vppn  in  19  TLBEHI.VPPN.
- csr_asid  in  10  ASID.ASID.
- csr_idx_index  in  IW  TLBIDX.INDEX.
- csr_idx_ps  in  6  TLBIDX.PS.
- csr_idx_ne  in  1  TLBIDX.NE.
- csr_elo0, csr_elo1  in  26 each  {ppn[25:6], mat[5:4], plv[3:2], d[1], v[0]}.
- csr_g  in  1  TLBELO0.G & TLBELO1.G.
- csr_tlbr_mode  in  1  ESTAT.Ecode==TLBR; forces w_e=1.
- done  out  1  one-cycle completion pulse.
- op_ine  out  1  valid with done; high for illegal op_type or inv_op>6.
- upd_idx_we  out  1  with done: write TLBIDX.NE/INDEX/PS.
- upd_idx_ne, upd_idx_index, upd_idx_ps  out  1/IW/6  TLBIDX update values.
- upd_entry_we  out  1  with done: write TLBEHI.VPPN, TLBELO0/1, G, ASID.ASID.
- upd_vppn, upd_asid, upd_elo0, upd_elo1, upd_g  out  19/10/26/26/1  entry update values.
- tlb_s_sel  out  1  high: TLB search port 1 is driven by this block.
- tlb_s_vppn, tlb_s_asid  out  19/10  search/invtlb key.
- tlb_s_found, tlb_s_index  in  1/IW  search result.
- tlb_r_index  out  IW  read index.
- tlb_r_e, tlb_r_vppn, tlb_r_ps, tlb_r_asid, tlb_r_g, tlb_r_elo0, tlb_r_elo1  in  read data in the same packing as csr_elo*.
- tlb_we, tlb_w_index, tlb_w_e, tlb_w_vppn, tlb_w_ps, tlb_w_asid, tlb_w_g, tlb_w_elo0, tlb_w_elo1  out  TLB write port.
- tlb_inv_valid, tlb_inv_op  out  1/5  TLB invalidate port.

## Operation
- **States:** IDLE -> EXEC -> RESP -> IDLE.
  - Illegal op_type or inv_op>6 goes IDLE -> RESP directly with op_ine=1, and no TLB access is made.
- **Accept:** on acceptance, latch op_type, inv_*, and all csr_* inputs. Later CSR changes do not affect the operation in flight.
- **EXEC (one cycle)** drives from the latched values:
  - SRCH: tlb_s_sel=1, key {csr_ehi_vppn, csr_asid}. Capture found/index at the end of EXEC.
  - RD: tlb_r_index=csr_idx_index. Capture all read data.
  - WR: tlb_we=1, w_index=csr_idx_index.
  - FILL: tlb_we=1, w_index=fill_ptr.
    - For both WR and FILL: w_e = csr_tlbr_mode | ~csr_idx_ne.
    - vppn/ps/asid/g/elo come from the latched CSRs.
  - INV: tlb_s_sel=1, key {inv_vppn, inv_asid}, tlb_inv_valid=1, tlb_inv_op=inv_op.
- **RESP (one cycle):** done=1, plus the CSR updates:
  - SRCH hit: upd_idx_we=1, ne=0, index=tlb_s_index.
  - SRCH miss: upd_idx_we=1, ne=1, index=latched csr_idx_index.
  - RD with e=1: upd_idx_we=upd_entry_we=1, ne=0, ps=tlb_r_ps, entry fields = read data.
  - RD with e=0: upd_idx_we=upd_entry_we=1, ne=1, ps=0, all entry fields 0.
  - WR/FILL/INV/illegal: no upd_*_we.
- **fill_ptr (IW bits):**
  - Reset value 0.
  - Increments by 1 at the end of each FILL EXEC and wraps TLBNUM-1 -> 0.
  - Not advanced by WR or illegal ops.
- All outputs other than op_ready are 0 outside the states that assert them.

## Timing
- Accept at edge N means EXEC occupies cycle N+1 and done is high in cycle N+2. This latency is fixed for all legal ops. Illegal ops return done in cycle N+1.
- tlb_we, tlb_inv_valid and tlb_s_sel are high for exactly one cycle per operation.
- op_ready is low from the accept edge until RESP ends; back-to-back ops have 3-cycle spacing.
- A TLB write committed at the EXEC edge is visible to a following RD's EXEC.
- **Reset:** all outputs 0, op_ready=1 in the cycle after reset, fill_ptr=0, state IDLE.
- **Reset mid-operation:** reset asserted during EXEC means the TLB sees tlb_we/tlb_inv_valid for that cycle only if rst is sampled low. At the next edge the state is IDLE, and there is no done and no upd_* pulse afterwards.
- op_valid with op_ready low is ignored; it is not queued.

## Test plan
- WR index 5 (vppn=0x12345, asid=0x3, ne=0), then SRCH with the same key -> done at N+2; upd_idx_we=1, ne=0, index=5.
- SRCH with vppn=0x7FFFF matching no entry -> upd_idx_ne=1, upd_idx_index equals the latched csr_idx_index.
- RD index 5 after the write -> upd_entry_we=1, vppn=0x12345, asid=0x3, ne=0. RD of an index never written after reset -> ne=1, all fields 0.
- 17 consecutive FILLs -> w_index sequence 0,1,...,15,0; the last write has w_e=1 when csr_idx_ne=1 and csr_tlbr_mode=1.
- INV with inv_op=5, asid=0x3, vppn=0x12345 -> tlb_inv_valid one cycle; a subsequent SRCH misses. INV with inv_op=9 -> done at N+1, op_ine=1, no tlb_inv_valid.
- Assert rst during the EXEC of a FILL -> no done; fill_ptr=0; op_ready=1 on the cycle after reset.

Source files
------------

// File: rtl/tlb_op_unit.sv
// Sequencer for TLB maintenance instructions: latches operands from EX/CSRs,
// performs one TLB access in EXEC, and returns CSR update data with done in RESP.
module tlb_op_unit #(
  parameter int TLBNUM = 16,
  localparam int IW = $clog2(TLBNUM)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          op_valid,
  output logic          op_ready,
  input  logic [2:0]    op_type,
  input  logic [4:0]    inv_op,
  input  logic [9:0]    inv_asid,
  input  logic [18:0]   inv_vppn,
  input  logic [18:0]   csr_ehi_vppn,
  input  logic [9:0]    csr_asid,
  input  logic [IW-1:0] csr_idx_index,
  input  logic [5:0]    csr_idx_ps,
  input  logic          csr_idx_ne,
  input  logic [25:0]   csr_elo0,
  input  logic [25:0]   csr_elo1,
  input  logic          csr_g,
  input  logic          csr_tlbr_mode,
  output logic          done,
  output logic          op_ine,
  output logic          upd_idx_we,
  output logic          upd_idx_ne,
  output logic [IW-1:0] upd_idx_index,
  output logic [5:0]    upd_idx_ps,
  output logic          upd_entry_we,
  output logic [18:0]   upd_vppn,
  output logic [9:0]    upd_asid,
  output logic [25:0]   upd_elo0,
  output logic [25:0]   upd_elo1,
  output logic          upd_g,
  output logic          tlb_s_sel,
  output logic [18:0]   tlb_s_vppn,
  output logic [9:0]    tlb_s_asid,
  input  logic          tlb_s_found,
  input  logic [IW-1:0] tlb_s_index,
  output logic [IW-1:0] tlb_r_index,
  input  logic          tlb_r_e,
  input  logic [18:0]   tlb_r_vppn,
  input  logic [5:0]    tlb_r_ps,
  input  logic [9:0]    tlb_r_asid,
  input  logic          tlb_r_g,
  input  logic [25:0]   tlb_r_elo0,
  input  logic [25:0]   tlb_r_elo1,
  output logic          tlb_we,
  output logic [IW-1:0] tlb_w_index,
  output logic          tlb_w_e,
  output logic [18:0]   tlb_w_vppn,
  output logic [5:0]    tlb_w_ps,
  output logic [9:0]    tlb_w_asid,
  output logic          tlb_w_g,
  output logic [25:0]   tlb_w_elo0,
  output logic [25:0]   tlb_w_elo1,
  output logic          tlb_inv_valid,
  output logic [4:0]    tlb_inv_op
);
  localparam logic [1:0] S_IDLE = 2'd0, S_EXEC = 2'd1, S_RESP = 2'd2;
  localparam logic [2:0] OP_SRCH = 3'd0, OP_RD = 3'd1, OP_WR = 3'd2,
                         OP_FILL = 3'd3, OP_INV = 3'd4;

  logic [1:0]    state;
  logic [2:0]    op_q;
  logic [4:0]    inv_op_q;
  logic [9:0]    inv_asid_q, asid_q;
  logic [18:0]   inv_vppn_q, vppn_q;
  logic [IW-1:0] idx_q, fill_ptr;
  logic [5:0]    ps_q;
  logic          ne_q, g_q, tlbr_q, ine_q;
  logic [25:0]   elo0_q, elo1_q;
  logic          found_q, r_e_q, r_g_q;
  logic [IW-1:0] s_index_q;
  logic [18:0]   r_vppn_q;
  logic [5:0]    r_ps_q;
  logic [9:0]    r_asid_q;
  logic [25:0]   r_elo0_q, r_elo1_q;
  logic          illegal;

  assign illegal = (op_type > OP_INV) || ((op_type == OP_INV) && (inv_op > 5'd6));

  // Handshake: a request is taken on any edge where op_valid && op_ready;
  // op_ready is high only in IDLE, and a request seen while it is low is dropped.
  assign op_ready = (state == S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      fill_ptr <= '0;
      ine_q    <= 1'b0;
      op_q     <= OP_SRCH;
    end else begin
      case (state)
        S_IDLE: if (op_valid) begin
          op_q       <= op_type;
          inv_op_q   <= inv_op;
          inv_asid_q <= inv_asid;
          inv_vppn_q <= inv_vppn;
          vppn_q     <= csr_ehi_vppn;
          asid_q     <= csr_asid;
          idx_q      <= csr_idx_index;
          ps_q       <= csr_idx_ps;
          ne_q       <= csr_idx_ne;
          elo0_q     <= csr_elo0;
          elo1_q     <= csr_elo1;
          g_q        <= csr_g;
          tlbr_q     <= csr_tlbr_mode;
          ine_q      <= illegal;
          state      <= illegal ? S_RESP : S_EXEC;
        end
        S_EXEC: begin
          found_q   <= tlb_s_found;
          s_index_q <= tlb_s_index;
          r_e_q     <= tlb_r_e;
          r_vppn_q  <= tlb_r_vppn;
          r_ps_q    <= tlb_r_ps;
          r_asid_q  <= tlb_r_asid;
          r_g_q     <= tlb_r_g;
          r_elo0_q  <= tlb_r_elo0;
          r_elo1_q  <= tlb_r_elo1;
          if (op_q == OP_FILL)
            fill_ptr <= (fill_ptr == IW'(TLBNUM - 1)) ? '0 : fill_ptr + IW'(1);
          state <= S_RESP;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Write and invalidate strobes are masked by rst so a reset during EXEC
  // leaves the TLB untouched.
  always_comb begin
    done = 1'b0; op_ine = 1'b0;
    upd_idx_we = 1'b0; upd_idx_ne = 1'b0; upd_idx_index = '0; upd_idx_ps = '0;
    upd_entry_we = 1'b0; upd_vppn = '0; upd_asid = '0; upd_elo0 = '0;
    upd_elo1 = '0; upd_g = 1'b0;
    tlb_s_sel = 1'b0; tlb_s_vppn = '0; tlb_s_asid = '0; tlb_r_index = '0;
    tlb_we = 1'b0; tlb_w_index = '0; tlb_w_e = 1'b0; tlb_w_vppn = '0;
    tlb_w_ps = '0; tlb_w_asid = '0; tlb_w_g = 1'b0; tlb_w_elo0 = '0;
    tlb_w_elo1 = '0; tlb_inv_valid = 1'b0; tlb_inv_op = '0;
    if (state == S_EXEC) begin
      case (op_q)
        OP_SRCH: begin
          tlb_s_sel  = 1'b1;
          tlb_s_vppn = vppn_q;
          tlb_s_asid = asid_q;
        end
        OP_RD: tlb_r_index = idx_q;
        OP_WR, OP_FILL: begin
          tlb_we      = ~rst;
          tlb_w_index = (op_q == OP_WR) ? idx_q : fill_ptr;
          tlb_w_e     = tlbr_q | ~ne_q;
          tlb_w_vppn  = vppn_q;
          tlb_w_ps    = ps_q;
          tlb_w_asid  = asid_q;
          tlb_w_g     = g_q;
          tlb_w_elo0  = elo0_q;
          tlb_w_elo1  = elo1_q;
        end
        OP_INV: begin
          tlb_s_sel     = 1'b1;
          tlb_s_vppn    = inv_vppn_q;
          tlb_s_asid    = inv_asid_q;
          tlb_inv_valid = ~rst;
          tlb_inv_op    = inv_op_q;
        end
        default: ;
      endcase
    end else if (state == S_RESP) begin
      done   = 1'b1;
      op_ine = ine_q;
      if (!ine_q && op_q == OP_SRCH) begin
        upd_idx_we    = 1'b1;
        upd_idx_ne    = ~found_q;
        upd_idx_index = found_q ? s_index_q : idx_q;
        upd_idx_ps    = ps_q;
      end else if (!ine_q && op_q == OP_RD) begin
        upd_idx_we    = 1'b1;
        upd_entry_we  = 1'b1;
        upd_idx_ne    = ~r_e_q;
        upd_idx_index = idx_q;
        if (r_e_q) begin
          upd_idx_ps = r_ps_q;
          upd_vppn   = r_vppn_q;
          upd_asid   = r_asid_q;
          upd_g      = r_g_q;
          upd_elo0   = r_elo0_q;
          upd_elo1   = r_elo1_q;
        end
      end
    end
  end
endmodule

// File: tb/tb_tlb_op_unit.sv
// Randomized bench for tlb_op_unit: a behavioural 16-entry TLB answers the DUT,
// and an independent reference TLB predicts every pulse and CSR update.
module tb_tlb_op_unit;
  localparam int IW = 4;

  typedef struct packed {
    logic        e;
    logic [18:0] vppn;
    logic [5:0]  ps;
    logic [9:0]  asid;
    logic        g;
    logic [25:0] elo0;
    logic [25:0] elo1;
  } ent_t;

  logic clk = 1'b0, rst = 1'b1, env_clr = 1'b1;
  logic op_valid = 1'b0, op_ready;
  logic [2:0] op_type = '0;
  logic [4:0] inv_op = '0;
  logic [9:0] inv_asid = '0, csr_asid = '0;
  logic [18:0] inv_vppn = '0, csr_ehi_vppn = '0;
  logic [IW-1:0] csr_idx_index = '0;
  logic [5:0] csr_idx_ps = '0;
  logic csr_idx_ne = 1'b0, csr_g = 1'b0, csr_tlbr_mode = 1'b0;
  logic [25:0] csr_elo0 = '0, csr_elo1 = '0;
  logic done, op_ine, upd_idx_we, upd_idx_ne, upd_entry_we, upd_g;
  logic [IW-1:0] upd_idx_index, tlb_r_index, tlb_w_index;
  logic [5:0] upd_idx_ps, tlb_w_ps;
  logic [18:0] upd_vppn, tlb_s_vppn, tlb_w_vppn;
  logic [9:0] upd_asid, tlb_s_asid, tlb_w_asid;
  logic [25:0] upd_elo0, upd_elo1, tlb_w_elo0, tlb_w_elo1;
  logic tlb_s_sel, tlb_we, tlb_w_e, tlb_w_g, tlb_inv_valid;
  logic [4:0] tlb_inv_op;
  logic tlb_s_found;
  logic [IW-1:0] tlb_s_index;

  ent_t mem [16];
  ent_t ref_m [16];
  int ref_fill;
  int n_total = 0, n_bad = 0;
  logic [IW-1:0] last_w_index;
  logic [IW-1:0] exp_q[$];

  tlb_op_unit dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
    .op_type(op_type), .inv_op(inv_op), .inv_asid(inv_asid), .inv_vppn(inv_vppn),
    .csr_ehi_vppn(csr_ehi_vppn), .csr_asid(csr_asid), .csr_idx_index(csr_idx_index),
    .csr_idx_ps(csr_idx_ps), .csr_idx_ne(csr_idx_ne), .csr_elo0(csr_elo0),
    .csr_elo1(csr_elo1), .csr_g(csr_g), .csr_tlbr_mode(csr_tlbr_mode),
    .done(done), .op_ine(op_ine), .upd_idx_we(upd_idx_we), .upd_idx_ne(upd_idx_ne),
    .upd_idx_index(upd_idx_index), .upd_idx_ps(upd_idx_ps), .upd_entry_we(upd_entry_we),
    .upd_vppn(upd_vppn), .upd_asid(upd_asid), .upd_elo0(upd_elo0), .upd_elo1(upd_elo1),
    .upd_g(upd_g), .tlb_s_sel(tlb_s_sel), .tlb_s_vppn(tlb_s_vppn), .tlb_s_asid(tlb_s_asid),
    .tlb_s_found(tlb_s_found), .tlb_s_index(tlb_s_index), .tlb_r_index(tlb_r_index),
    .tlb_r_e(mem[tlb_r_index].e), .tlb_r_vppn(mem[tlb_r_index].vppn),
    .tlb_r_ps(mem[tlb_r_index].ps), .tlb_r_asid(mem[tlb_r_index].asid),
    .tlb_r_g(mem[tlb_r_index].g), .tlb_r_elo0(mem[tlb_r_index].elo0),
    .tlb_r_elo1(mem[tlb_r_index].elo1), .tlb_we(tlb_we), .tlb_w_index(tlb_w_index),
    .tlb_w_e(tlb_w_e), .tlb_w_vppn(tlb_w_vppn), .tlb_w_ps(tlb_w_ps),
    .tlb_w_asid(tlb_w_asid), .tlb_w_g(tlb_w_g), .tlb_w_elo0(tlb_w_elo0),
    .tlb_w_elo1(tlb_w_elo1), .tlb_inv_valid(tlb_inv_valid), .tlb_inv_op(tlb_inv_op)
  );

  // clock / reset
  always #5 clk = ~clk;

  // invtlb selection rule of the TLB
  function automatic logic inv_hit(ent_t en, logic [4:0] op, logic [9:0] a, logic [18:0] v);
    case (op)
      5'd0, 5'd1: return 1'b1;
      5'd2:       return en.g;
      5'd3:       return !en.g;
      5'd4:       return !en.g && en.asid == a;
      5'd5:       return !en.g && en.asid == a && en.vppn == v;
      5'd6:       return (en.g || en.asid == a) && en.vppn == v;
      default:    return 1'b0;
    endcase
  endfunction

  function automatic logic key_hit(ent_t en, logic [18:0] v, logic [9:0] a);
    return en.e && en.vppn == v && (en.g || en.asid == a);
  endfunction

  // behavioural TLB answering the DUT
  always_comb begin
    tlb_s_found = 1'b0;
    tlb_s_index = '0;
    for (int i = 15; i >= 0; i--)
      if (key_hit(mem[i], tlb_s_vppn, tlb_s_asid)) begin
        tlb_s_found = 1'b1;
        tlb_s_index = IW'(i);
      end
  end

  always @(posedge clk) begin
    if (env_clr) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else begin
      if (tlb_we)
        mem[tlb_w_index] <= '{tlb_w_e, tlb_w_vppn, tlb_w_ps, tlb_w_asid, tlb_w_g,
                               tlb_w_elo0, tlb_w_elo1};
      if (tlb_inv_valid)
        for (int i = 0; i < 16; i++)
          if (inv_hit(mem[i], tlb_inv_op, tlb_s_asid, tlb_s_vppn)) mem[i].e <= 1'b0;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic set_csr(input logic [18:0] v, input logic [9:0] a, input logic [IW-1:0] idx,
                         input logic ne, input logic g, input logic tlbr);
    csr_ehi_vppn = v; csr_asid = a; csr_idx_index = idx; csr_idx_ne = ne;
    csr_g = g; csr_tlbr_mode = tlbr;
    csr_idx_ps = 6'($urandom_range(0, 63));
    csr_elo0 = 26'($urandom); csr_elo1 = 26'($urandom);
  endtask

  task automatic scramble();
    op_type = 3'($urandom); inv_op = 5'($urandom); inv_asid = 10'($urandom);
    inv_vppn = 19'($urandom);
    set_csr(19'($urandom), 10'($urandom), IW'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom));
  endtask

  // driver + checker for one operation; called and returns on a negedge
  task automatic run_op(input logic [2:0] t);
    int guard = 0;
    logic [4:0] l_iop; logic [9:0] l_ia; logic [18:0] l_iv;
    ent_t l_c; logic [IW-1:0] l_idx; logic l_ne, l_tlbr;
    int done_cnt = 0, done_cyc = 0, we_cnt = 0, inv_cnt = 0, ssel_cnt = 0, rdy_lo = 0;
    logic o_ine = 0, o_iwe = 0, o_ewe = 0, o_ne = 0, o_g = 0, o_we_e = 0;
    logic [IW-1:0] o_index = 0, o_ridx = 0, o_widx = 0;
    logic [5:0] o_ps = 0; logic [18:0] o_vppn = 0, o_sv = 0; logic [9:0] o_asid = 0, o_sa = 0;
    logic [25:0] o_e0 = 0, o_e1 = 0; logic [4:0] o_iop = 0; ent_t o_w = '0;
    logic illegal, hit; logic [IW-1:0] hidx, widx; ent_t re, we_ent;

    while (!op_ready && guard < 8) begin @(negedge clk); guard++; end
    check_eq("ready_before_op", op_ready, 1'b1);
    op_type = t; op_valid = 1'b1;
    l_iop = inv_op; l_ia = inv_asid; l_iv = inv_vppn;
    l_c = '{1'b0, csr_ehi_vppn, csr_idx_ps, csr_asid, csr_g, csr_elo0, csr_elo1};
    l_idx = csr_idx_index; l_ne = csr_idx_ne; l_tlbr = csr_tlbr_mode;
    @(posedge clk);
    #1 op_valid = 1'b0;
    scramble();
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (!op_ready) rdy_lo++;
      if (c == 1) o_ridx = tlb_r_index;
      if (done) begin
        done_cnt++; done_cyc = c; o_ine = op_ine; o_iwe = upd_idx_we; o_ewe = upd_entry_we;
        o_ne = upd_idx_ne; o_index = upd_idx_index; o_ps = upd_idx_ps; o_vppn = upd_vppn;
        o_asid = upd_asid; o_g = upd_g; o_e0 = upd_elo0; o_e1 = upd_elo1;
      end
      if (tlb_we) begin
        we_cnt++; o_widx = tlb_w_index; o_we_e = tlb_w_e;
        o_w = '{tlb_w_e, tlb_w_vppn, tlb_w_ps, tlb_w_asid, tlb_w_g, tlb_w_elo0, tlb_w_elo1};
      end
      if (tlb_inv_valid) begin inv_cnt++; o_iop = tlb_inv_op; end
      if (tlb_s_sel) begin ssel_cnt++; o_sv = tlb_s_vppn; o_sa = tlb_s_asid; end
    end

    illegal = (t > 3'd4) || (t == 3'd4 && l_iop > 5'd6);
    check_eq("done_cnt", 64'(done_cnt), 64'd1);
    check_eq("done_cycle", 64'(done_cyc), illegal ? 64'd1 : 64'd2);
    check_eq("ready_low_cycles", 64'(rdy_lo), illegal ? 64'd1 : 64'd2);
    check_eq("op_ine", o_ine, illegal);
    check_eq("we_cnt", 64'(we_cnt), 64'(!illegal && (t == 3'd2 || t == 3'd3)));
    check_eq("inv_cnt", 64'(inv_cnt), 64'(!illegal && t == 3'd4));
    check_eq("s_sel_cnt", 64'(ssel_cnt), 64'(!illegal && (t == 3'd0 || t == 3'd4)));
    check_eq("upd_idx_we", o_iwe, !illegal && (t == 3'd0 || t == 3'd1));
    check_eq("upd_entry_we", o_ewe, !illegal && t == 3'd1);
    if (illegal) return;

    case (t)
      3'd0: begin
        hit = 1'b0; hidx = '0;
        for (int i = 15; i >= 0; i--)
          if (key_hit(ref_m[i], l_c.vppn, l_c.asid)) begin hit = 1'b1; hidx = IW'(i); end
        check_eq("srch_key_vppn", o_sv, l_c.vppn);
        check_eq("srch_key_asid", o_sa, l_c.asid);
        check_eq("srch_ne", o_ne, !hit);
        check_eq("srch_index", o_index, hit ? hidx : l_idx);
      end
      3'd1: begin
        re = ref_m[l_idx];
        if (!re.e) re = '0;
        check_eq("rd_r_index", o_ridx, l_idx);
        check_eq("rd_ne", o_ne, !re.e);
        check_eq("rd_ps", o_ps, re.ps);
        check_eq("rd_vppn", o_vppn, re.vppn);
        check_eq("rd_asid", o_asid, re.asid);
        check_eq("rd_g", o_g, re.g);
        check_eq("rd_elo0", o_e0, re.elo0);
        check_eq("rd_elo1", o_e1, re.elo1);
      end
      3'd2, 3'd3: begin
        widx = (t == 3'd2) ? l_idx : IW'(ref_fill);
        we_ent = l_c;
        we_ent.e = l_tlbr | ~l_ne;
        check_eq("w_index", o_widx, widx);
        check_eq("w_e", o_we_e, we_ent.e);
        check_eq("w_entry_lo", o_w[63:0], we_ent[63:0]);
        check_eq("w_entry_hi", 64'(o_w[88:64]), 64'(we_ent[88:64]));
        last_w_index = o_widx;
        ref_m[widx] = we_ent;
        if (t == 3'd3) ref_fill = (ref_fill + 1) % 16;
      end
      default: begin
        check_eq("inv_op", o_iop, l_iop);
        check_eq("inv_key_vppn", o_sv, l_iv);
        check_eq("inv_key_asid", o_sa, l_ia);
        for (int i = 0; i < 16; i++)
          if (inv_hit(ref_m[i], l_iop, l_ia, l_iv)) ref_m[i].e = 1'b0;
      end
    endcase
  endtask

  logic [18:0] pool_v [4];
  logic [9:0]  pool_a [2];

  initial begin
    int nd, nu;
    pool_v[0] = 19'h12345; pool_v[1] = 19'h00001; pool_v[2] = 19'h7FFFF; pool_v[3] = 19'h2AAAA;
    pool_a[0] = 10'h3; pool_a[1] = 10'h5;
    for (int i = 0; i < 16; i++) ref_m[i] = '0;
    ref_fill = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; env_clr = 1'b0;
    @(negedge clk);
    check_eq("reset_ready", op_ready, 1'b1);
    check_eq("reset_done", done, 1'b0);
    check_eq("reset_strobes", {tlb_we, tlb_inv_valid, tlb_s_sel, upd_idx_we, upd_entry_we, op_ine}, 6'd0);

    // directed scenarios
    set_csr(19'h12345, 10'h3, 4'd5, 1'b0, 1'b0, 1'b0); run_op(3'd2);
    set_csr(19'h12345, 10'h3, 4'd9, 1'b0, 1'b0, 1'b0); run_op(3'd0);
    set_csr(19'h7FFFF, 10'h3, 4'd11, 1'b0, 1'b0, 1'b0); run_op(3'd0);
    set_csr(19'h0, 10'h0, 4'd5, 1'b1, 1'b0, 1'b0); run_op(3'd1);
    set_csr(19'h0, 10'h0, 4'd9, 1'b0, 1'b0, 1'b0); run_op(3'd1);
    inv_op = 5'd5; inv_asid = 10'h3; inv_vppn = 19'h12345; run_op(3'd4);
    set_csr(19'h12345, 10'h3, 4'd2, 1'b0, 1'b0, 1'b0); run_op(3'd0);
    inv_op = 5'd9; run_op(3'd4);
    run_op(3'd6);

    // 17 consecutive fills: indices wrap through every entry back to 0
    for (int i = 0; i < 17; i++) exp_q.push_back(IW'(i % 16));
    for (int i = 0; i < 17; i++) begin
      if (i == 16) set_csr(19'h2AAAA, 10'h5, 4'd7, 1'b1, 1'b0, 1'b1);
      else set_csr(pool_v[$urandom_range(0, 3)], pool_a[$urandom_range(0, 1)], IW'($urandom),
                   1'($urandom), 1'($urandom), 1'($urandom));
      run_op(3'd3);
      check_eq("fill_seq", last_w_index, exp_q.pop_front());
    end

    // write followed immediately by a read of the same index
    set_csr(19'h00001, 10'h5, 4'd12, 1'b0, 1'b1, 1'b0); run_op(3'd2);
    set_csr(19'h0, 10'h0, 4'd12, 1'b0, 1'b0, 1'b0); run_op(3'd1);

    // randomized mix of operations
    for (int n = 0; n < 60; n++) begin
      set_csr(pool_v[$urandom_range(0, 3)], pool_a[$urandom_range(0, 1)], IW'($urandom),
              ($urandom_range(0, 3) == 0), 1'($urandom), ($urandom_range(0, 3) == 0));
      inv_op = 5'($urandom_range(0, 7));
      inv_asid = pool_a[$urandom_range(0, 1)];
      inv_vppn = pool_v[$urandom_range(0, 3)];
      run_op(3'($urandom_range(0, 7)));
    end

    // reset during the EXEC of a FILL
    if (ref_fill == 0) begin set_csr(19'h1, 10'h3, 4'd0, 1'b0, 1'b0, 1'b0); run_op(3'd3); end
    set_csr(19'h2AAAA, 10'h3, 4'd0, 1'b0, 1'b0, 1'b0);
    op_type = 3'd3; op_valid = 1'b1;
    @(posedge clk);
    #1 op_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    check_eq("rst_exec_we", tlb_we, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    ref_fill = 0;
    nd = 0; nu = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 0) check_eq("ready_after_rst", op_ready, 1'b1);
      if (done) nd++;
      if (upd_idx_we || upd_entry_we) nu++;
    end
    check_eq("rst_no_done", 64'(nd), 64'd0);
    check_eq("rst_no_upd", 64'(nu), 64'd0);
    set_csr(19'h00001, 10'h3, 4'd6, 1'b0, 1'b0, 1'b0); run_op(3'd3);
    check_eq("fill_after_rst", last_w_index, 4'd0);
    set_csr(19'h0, 10'h0, 4'd0, 1'b0, 1'b0, 1'b0); run_op(3'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
